// File: rtl/pwm_seq.sv
// pwm_seq: table-driven bus-master sequencer for the 4-channel PWM peripheral.
//
// Plays up to DEPTH (channel, period, high-time, hold) entries in order. For
// each entry it writes the PWM period (A_n) and high-time (B_n) registers and
// then waits the hold time. The sequence starts by enabling the PWM (C <= 0)
// and ends by disabling its outputs (C <= 1), optionally looping forever.
//
// Optional build macro: PWM_SEQ_IRQ_EN adds a sticky irq_o flag, set when a
// sequence ends and cleared by writing 1 to STATUS bit0. STATUS bit31 reads it.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_we_i/addr_i/data_i   config write port; addr[9:8] region, [IW+1:2] index
//   cfg_data_o               combinational config read data
//   start_i, stop_i          start pulse (ignored while busy), abort pulse
//   pwm_we_o/addr_o/data_o   PWM register write port (one strobe per write)
//   busy_o, done_o, idx_o    status: running, end-of-sequence pulse, entry index
//   irq_o                    sticky done interrupt (PWM_SEQ_IRQ_EN only)
module pwm_seq #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] PWM_BASE = 32'h4000_0000,
  localparam int         IW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we_i,
  input  logic [31:0]   cfg_addr_i,
  input  logic [31:0]   cfg_data_i,
  output logic [31:0]   cfg_data_o,
  input  logic          start_i,
  input  logic          stop_i,
  output logic          pwm_we_o,
  output logic [31:0]   pwm_addr_o,
  output logic [31:0]   pwm_data_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [IW-1:0] idx_o
`ifdef PWM_SEQ_IRQ_EN
  ,
  output logic          irq_o
`endif
);

  localparam logic [7:0]    C_CODE  = 8'h04;
  localparam logic [7:0]    B_BASE  = 8'h0A;
  localparam logic [IW-1:0] ONE     = 1;
  localparam logic [IW-1:0] MAX_IDX = '1;

  typedef enum logic [2:0] {
    IDLE,
    EN,
    LOAD,
    WR_A,
    WR_B,
    HOLD,
    DIS
  } state_t;

  state_t          state_reg;
  logic [IW-1:0]   idx_reg;
  logic [31:0]     high_lat_reg;
  logic [31:0]     hold_lat_reg;
  logic [31:0]     hold_cnt_reg;

  // Configuration storage
  logic            loop_reg;
  logic [IW:0]     last_reg;
  logic [31:0]     period_tbl [DEPTH];
  logic [31:0]     high_tbl   [DEPTH];
  logic [31:0]     hold_tbl   [DEPTH];

  logic [1:0]      cfg_region;
  logic [IW-1:0]   cfg_idx;
  logic [IW-1:0]   last_eff;
  logic [3:0]      idx_wide;
  logic [1:0]      ch;
  logic [7:0]      a_code;
  logic [7:0]      b_code;
  logic            status_clr;

  assign cfg_region = cfg_addr_i[9:8];
  assign cfg_idx    = cfg_addr_i[IW+1:2];

  // DEPTH is a power of two, so a stored last index >= DEPTH is exactly the
  // case where its top bit is set; clamp it to the final entry.
  assign last_eff = last_reg[IW] ? MAX_IDX : last_reg[IW-1:0];

  // Widen the index so the channel select also works for DEPTH=2.
  assign idx_wide = 4'(idx_reg);
  assign ch       = idx_wide[1:0];
  assign a_code   = {6'b0, ch};
  assign b_code   = B_BASE + {6'b0, ch};

  assign status_clr = cfg_we_i && (cfg_region == 2'd0) && (cfg_idx == ONE)
                      && cfg_data_i[0];

  assign busy_o = (state_reg != IDLE);
  assign idx_o  = idx_reg;

  // Configuration writes are accepted in any state; the sequencer only
  // samples an entry in LOAD, so edits apply the next time it is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_reg <= 1'b0;
      last_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        period_tbl[i] <= '0;
        high_tbl[i]   <= '0;
        hold_tbl[i]   <= '0;
      end
    end else if (cfg_we_i) begin
      case (cfg_region)
        2'd0: begin
          if (cfg_idx == '0) begin
            loop_reg <= cfg_data_i[0];
            last_reg <= cfg_data_i[IW+8:8];
          end
        end
        2'd1:    period_tbl[cfg_idx] <= cfg_data_i;
        2'd2:    high_tbl[cfg_idx]   <= cfg_data_i;
        default: hold_tbl[cfg_idx]   <= cfg_data_i;
      endcase
    end
  end

  // Sequencer. Bus outputs are registered and loaded on the transition into
  // the state that owns the write, so each write is visible during that state.
  // Address/data are only reloaded with a strobe and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      high_lat_reg <= '0;
      hold_lat_reg <= '0;
      hold_cnt_reg <= '0;
      pwm_we_o     <= 1'b0;
      pwm_addr_o   <= '0;
      pwm_data_o   <= '0;
      done_o       <= 1'b0;
`ifdef PWM_SEQ_IRQ_EN
      irq_o        <= 1'b0;
`endif
    end else begin
      pwm_we_o <= 1'b0;
      done_o   <= 1'b0;
`ifdef PWM_SEQ_IRQ_EN
      if (status_clr) irq_o <= 1'b0;
`endif
      if (stop_i && state_reg != IDLE && state_reg != DIS) begin
        // Abort: whatever write is on the bus this cycle completes, the
        // disable write follows.
        state_reg  <= DIS;
        pwm_we_o   <= 1'b1;
        pwm_addr_o <= {PWM_BASE[31:24], C_CODE, 16'h0000};
        pwm_data_o <= 32'd1;
        done_o     <= 1'b1;
`ifdef PWM_SEQ_IRQ_EN
        irq_o      <= 1'b1;
`endif
      end else begin
        case (state_reg)
          IDLE: begin
            if (start_i && !stop_i) begin
              state_reg  <= EN;
              idx_reg    <= '0;
              pwm_we_o   <= 1'b1;
              pwm_addr_o <= {PWM_BASE[31:24], C_CODE, 16'h0000};
              pwm_data_o <= 32'd0;
            end
          end
          EN: begin
            state_reg <= LOAD;
          end
          LOAD: begin
            // Period goes straight into the write-data register for WR_A.
            state_reg    <= WR_A;
            high_lat_reg <= high_tbl[idx_reg];
            hold_lat_reg <= hold_tbl[idx_reg];
            pwm_we_o     <= 1'b1;
            pwm_addr_o   <= {PWM_BASE[31:24], a_code, 16'h0000};
            pwm_data_o   <= period_tbl[idx_reg];
          end
          WR_A: begin
            state_reg  <= WR_B;
            pwm_we_o   <= 1'b1;
            pwm_addr_o <= {PWM_BASE[31:24], b_code, 16'h0000};
            pwm_data_o <= high_lat_reg;
          end
          WR_B: begin
            state_reg    <= HOLD;
            hold_cnt_reg <= hold_lat_reg;
          end
          HOLD: begin
            // A hold of 0 behaves like 1: always at least one HOLD cycle.
            if (hold_cnt_reg <= 32'd1) begin
              if (idx_reg == last_eff) begin
                if (loop_reg) begin
                  state_reg <= LOAD;
                  idx_reg   <= '0;
                end else begin
                  state_reg  <= DIS;
                  pwm_we_o   <= 1'b1;
                  pwm_addr_o <= {PWM_BASE[31:24], C_CODE, 16'h0000};
                  pwm_data_o <= 32'd1;
                  done_o     <= 1'b1;
`ifdef PWM_SEQ_IRQ_EN
                  irq_o      <= 1'b1;
`endif
                end
              end else begin
                state_reg <= LOAD;
                idx_reg   <= idx_reg + ONE;
              end
            end else begin
              hold_cnt_reg <= hold_cnt_reg - 32'd1;
            end
          end
          DIS: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  // Combinational config read; unmapped locations read 0.
  always_comb begin
    cfg_data_o = '0;
    case (cfg_region)
      2'd0: begin
        if (cfg_idx == '0) begin
          cfg_data_o[0]      = loop_reg;
          cfg_data_o[IW+8:8] = last_reg;
        end else if (cfg_idx == ONE) begin
          cfg_data_o[IW:0] = {busy_o, idx_reg};
`ifdef PWM_SEQ_IRQ_EN
          cfg_data_o[31]   = irq_o;
`endif
        end
      end
      2'd1:    cfg_data_o = period_tbl[cfg_idx];
      2'd2:    cfg_data_o = high_tbl[cfg_idx];
      default: cfg_data_o = hold_tbl[cfg_idx];
    endcase
  end

  // Address bits outside the region/index fields are don't-care.
  logic unused_ok;
  assign unused_ok = &{1'b0, cfg_addr_i[31:10], cfg_addr_i[7:IW+2],
                       cfg_addr_i[1:0], status_clr};

endmodule

// File: tb/tb_pwm_seq.sv
// tb_pwm_seq: directed, cycle-exact self-checking bench for pwm_seq.
// Each cycle of a sequence is checked against hand-derived expectations for
// the PWM write port, done/busy and the entry index.
module tb_pwm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we_i;
  logic [31:0] cfg_addr_i;
  logic [31:0] cfg_data_i;
  logic [31:0] cfg_data_o;
  logic        start_i;
  logic        stop_i;
  logic        pwm_we_o;
  logic [31:0] pwm_addr_o;
  logic [31:0] pwm_data_o;
  logic        busy_o;
  logic        done_o;
  logic [2:0]  idx_o;
`ifdef PWM_SEQ_IRQ_EN
  logic        irq_o;
`endif

  pwm_seq dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we_i   (cfg_we_i),
    .cfg_addr_i (cfg_addr_i),
    .cfg_data_i (cfg_data_i),
    .cfg_data_o (cfg_data_o),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .pwm_we_o   (pwm_we_o),
    .pwm_addr_o (pwm_addr_o),
    .pwm_data_o (pwm_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .idx_o      (idx_o)
`ifdef PWM_SEQ_IRQ_EN
    ,
    .irq_o      (irq_o)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;
  logic [31:0] m_period [8];
  logic [31:0] m_high   [8];
  logic [31:0] m_hold   [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock (inputs set beforehand are sampled at this edge, then
  // dropped) and check the state of the cycle that follows.
  task automatic exp_cyc(input string tag, input bit we, input logic [7:0] code,
                         input logic [31:0] data, input bit dn, input bit bsy,
                         input int ix);
    @(posedge clk);
    #1;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    cfg_we_i = 1'b0;
    @(negedge clk);
    if (we) begin
      exp_addr = {8'h40, code, 16'h0000};
      exp_data = data;
    end
    if (pwm_we_o)
      $display("pwm write [%s] code=%h data=%0d", tag, pwm_addr_o[23:16], pwm_data_o);
    check({tag, ".we"},   32'(pwm_we_o), 32'(we));
    check({tag, ".addr"}, pwm_addr_o, exp_addr);
    check({tag, ".data"}, pwm_data_o, exp_data);
    check({tag, ".done"}, 32'(done_o), 32'(dn));
    check({tag, ".busy"}, 32'(busy_o), 32'(bsy));
    check({tag, ".idx"},  32'(idx_o), 32'(ix[2:0]));
  endtask

  task automatic cfg_wr(input int region, input int index, input logic [31:0] data);
    cfg_we_i   = 1'b1;
    cfg_addr_i = 32'((region << 8) | (index << 2));
    cfg_data_i = data;
    if (region == 1) m_period[index] = data;
    if (region == 2) m_high[index]   = data;
    if (region == 3) m_hold[index]   = data;
    @(posedge clk);
    #1;
    cfg_we_i = 1'b0;
    @(negedge clk);
    $display("cfg write region=%0d index=%0d data=%h", region, index, data);
  endtask

  task automatic cfg_rd_chk(input string tag, input int region, input int index,
                            input logic [31:0] exp);
    cfg_addr_i = 32'((region << 8) | (index << 2));
    #1;
    $display("cfg read region=%0d index=%0d data=%h", region, index, cfg_data_o);
    check(tag, cfg_data_o, exp);
  endtask

  task automatic start_seq();
    start_i = 1'b1;
    exp_cyc("en", 1'b1, 8'h04, 32'd0, 1'b0, 1'b1, 0);
  endtask

  task automatic entry_head(input int i);
    exp_cyc("load", 1'b0, 8'h00, 32'd0, 1'b0, 1'b1, i);
    exp_cyc("wr_a", 1'b1, 8'(i % 4), m_period[i], 1'b0, 1'b1, i);
    exp_cyc("wr_b", 1'b1, 8'h0A + 8'(i % 4), m_high[i], 1'b0, 1'b1, i);
  endtask

  task automatic play_entry(input int i);
    int n;
    entry_head(i);
    n = (m_hold[i] == 0) ? 1 : int'(m_hold[i]);
    for (int k = 0; k < n; k++)
      exp_cyc("hold", 1'b0, 8'h00, 32'd0, 1'b0, 1'b1, i);
  endtask

  task automatic finish_seq(input int i);
    exp_cyc("dis",  1'b1, 8'h04, 32'd1, 1'b1, 1'b1, i);
    exp_cyc("idle", 1'b0, 8'h00, 32'd0, 1'b0, 1'b0, i);
  endtask

  initial begin
    rst        = 1'b1;
    cfg_we_i   = 1'b0;
    cfg_addr_i = '0;
    cfg_data_i = '0;
    start_i    = 1'b0;
    stop_i     = 1'b0;
    exp_addr   = '0;
    exp_data   = '0;
    for (int i = 0; i < 8; i++) begin
      m_period[i] = '0;
      m_high[i]   = '0;
      m_hold[i]   = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.we",   32'(pwm_we_o), 32'd0);
    check("rst.addr", pwm_addr_o, 32'd0);
    check("rst.busy", 32'(busy_o), 32'd0);
    check("rst.done", 32'(done_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    cfg_rd_chk("rst.ctrl",    0, 0, 32'd0);
    cfg_rd_chk("rst.status",  0, 1, 32'd0);
    cfg_rd_chk("rst.period3", 1, 3, 32'd0);

    // Two-entry sequence, no loop
    cfg_wr(0, 0, 32'h0000_0100);
    cfg_wr(1, 0, 32'd100); cfg_wr(2, 0, 32'd40); cfg_wr(3, 0, 32'd5);
    cfg_wr(1, 1, 32'd200); cfg_wr(2, 1, 32'd50); cfg_wr(3, 1, 32'd3);
    cfg_rd_chk("rb.ctrl",  0, 0, 32'h0000_0100);
    cfg_rd_chk("rb.hold1", 3, 1, 32'd3);
    cfg_rd_chk("rb.unmapped", 0, 2, 32'd0);
    start_seq();
    play_entry(0);
    play_entry(1);
    finish_seq(1);
    cfg_rd_chk("status.end", 0, 1, 32'h1);
`ifdef PWM_SEQ_IRQ_EN
    check("irq.set", 32'(irq_o), 32'd1);
    cfg_rd_chk("status.irq", 0, 1, 32'h8000_0001);
    cfg_wr(0, 1, 32'd1);
    check("irq.clr", 32'(irq_o), 32'd0);
`endif

    // start together with stop in IDLE: nothing happens
    start_i = 1'b1;
    stop_i  = 1'b1;
    exp_cyc("ss.idle0", 1'b0, 8'h00, 32'd0, 1'b0, 1'b0, 1);
    exp_cyc("ss.idle1", 1'b0, 8'h00, 32'd0, 1'b0, 1'b0, 1);

    // stop during the second HOLD cycle of entry 0
    start_seq();
    entry_head(0);
    exp_cyc("stop.hold1", 1'b0, 8'h00, 32'd0, 1'b0, 1'b1, 0);
    exp_cyc("stop.hold2", 1'b0, 8'h00, 32'd0, 1'b0, 1'b1, 0);
    stop_i = 1'b1;
    finish_seq(0);

    // Edit PERIOD1 during entry 0's hold; start while busy is ignored
    start_seq();
    entry_head(0);
    exp_cyc("ed.hold1", 1'b0, 8'h00, 32'd0, 1'b0, 1'b1, 0);
    start_i = 1'b1;
    exp_cyc("ed.hold2", 1'b0, 8'h00, 32'd0, 1'b0, 1'b1, 0);
    cfg_rd_chk("ed.status_busy", 0, 1, 32'h8);
    cfg_we_i    = 1'b1;
    cfg_addr_i  = 32'((1 << 8) | (1 << 2));
    cfg_data_i  = 32'd300;
    m_period[1] = 32'd300;
    exp_cyc("ed.hold3", 1'b0, 8'h00, 32'd0, 1'b0, 1'b1, 0);
    exp_cyc("ed.hold4", 1'b0, 8'h00, 32'd0, 1'b0, 1'b1, 0);
    exp_cyc("ed.hold5", 1'b0, 8'h00, 32'd0, 1'b0, 1'b1, 0);
    play_entry(1);
    finish_seq(1);

    // Loop on entry 0 with HOLD0=0, then abort during WR_A
    cfg_wr(0, 0, 32'h0000_0001);
    cfg_wr(3, 0, 32'd0);
    start_seq();
    for (int r = 0; r < 3; r++) play_entry(0);
    exp_cyc("lp.load", 1'b0, 8'h00, 32'd0, 1'b0, 1'b1, 0);
    exp_cyc("lp.wr_a", 1'b1, 8'h00, 32'd100, 1'b0, 1'b1, 0);
    stop_i = 1'b1;
    finish_seq(0);

    // last=9 clamps to 7: all eight entries play
    cfg_wr(0, 0, 32'h0000_0900);
    cfg_wr(3, 1, 32'd0);
    cfg_wr(1, 7, 32'd77);
    cfg_wr(2, 7, 32'd7);
    start_seq();
    for (int i = 0; i < 8; i++) play_entry(i);
    finish_seq(7);

    // Asynchronous reset during WR_B
    cfg_wr(0, 0, 32'd0);
    start_seq();
    entry_head(0);
    rst = 1'b1;
    #1;
    check("arst.we",   32'(pwm_we_o), 32'd0);
    check("arst.busy", 32'(busy_o), 32'd0);
    check("arst.data", pwm_data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    for (int i = 0; i < 8; i++) begin
      m_period[i] = '0;
      m_high[i]   = '0;
      m_hold[i]   = '0;
    end
    cfg_rd_chk("arst.period0", 1, 0, 32'd0);
    cfg_rd_chk("arst.period7", 1, 7, 32'd0);
    cfg_rd_chk("arst.ctrl",    0, 0, 32'd0);
    start_seq();
    play_entry(0);
    finish_seq(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_seq.md
Name: pwm_seq

Overview:
- Bus-master sequencer that drives the 4-channel PWM peripheral through its register-write port (we/addr/data).
- Plays a small table of (channel, period, high-time, hold) entries in order.
- For each entry it writes the period (A_n) and high-time (B_n) registers, then waits the hold time before moving on.
- Lets firmware run multi-step PWM patterns (e.g. fades or beep sequences) without CPU involvement; sits between the CPU bus and the PWM block.

Parameters:
DEPTH, 8, number of table entries (power of two, 2..8); index width IW = $clog2(DEPTH)
PWM_BASE, 32'h4000_0000, PWM bus base; only bits [31:24] are used in pwm_addr_o

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_we_i  in  1  config register write strobe
cfg_addr_i  in  32  config address; [9:8] region, [IW+1:2] entry index
cfg_data_i  in  32  config write data
cfg_data_o  out  32  combinational read data
start_i  in  1  start pulse; ignored while busy_o=1
stop_i  in  1  abort pulse
pwm_we_o  out  1  PWM write strobe (one cycle per write)
pwm_addr_o  out  32  {PWM_BASE[31:24], code[7:0], 16'h0}
pwm_data_o  out  32  PWM write data
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse when the sequence ends normally or is aborted
idx_o  out  IW  current entry index

Behaviour:
- Config map, by region cfg_addr_i[9:8]:
  - 0: CTRL at index 0, R/W; bit0 = loop, bits [IW+8:8] = last entry index. STATUS at index 1, read-only; {busy, idx}.
  - 1: PERIOD[i].
  - 2: HIGH[i].
  - 3: HOLD[i], 32-bit cycle count.
- Unmapped reads return 0. Writes are accepted in any state.
- A table entry is sampled only in LOAD, so an edit takes effect the next time that entry is loaded.
- Reset: all outputs 0, state IDLE, all tables and CTRL 0, idx 0.
- Channel for entry i = i[1:0]. A code = 8'h00+ch; B code = 8'h0A+ch; C code = 8'h04.
- FSM:
  - IDLE: start_i & !stop_i -> EN; idx <= 0.
  - EN: pwm_we_o=1, C<=0 (enable PWM) -> LOAD.
  - LOAD: latch PERIOD/HIGH/HOLD[idx] -> WR_A.
  - WR_A: pwm_we_o=1, A code, data=period -> WR_B.
  - WR_B: pwm_we_o=1, B code, data=high -> HOLD; hold counter <= latched HOLD.
  - HOLD: counter decrements each cycle. At counter<=1 (HOLD=0 behaves as 1): if idx==last -> (loop ? LOAD with idx<=0 : DIS); else idx<=idx+1 -> LOAD.
  - DIS: pwm_we_o=1, C<=1 (disable outputs); done_o=1 -> IDLE.
- Latency: start to first PWM write (EN) is 1 cycle; start to A write is 3 cycles.
- stop_i in any busy state: next state is DIS. The current write, if any, still completes this cycle; stop_i in DIS is ignored.
- start_i and stop_i together in IDLE: stop wins, stays IDLE.
- last >= DEPTH is clamped to DEPTH-1.
- pwm_we_o is never high for two different codes in one cycle. When pwm_we_o=0, pwm_addr_o and pwm_data_o hold their last values.
- Async reset mid-sequence: immediate return to IDLE with pwm_we_o=0. No DIS write is issued.

Optional Feature:
PWM_SEQ_IRQ_EN:
- Defined: adds port irq_o (out, 1). irq_o is a sticky flag, set on done_o and cleared by a config write to STATUS with bit0=1. Reset value 0. STATUS bit31 reads irq.
- Undefined: no irq_o port; STATUS bit31 reads 0.

Test Plan:
- Reset, then read CTRL/STATUS/PERIOD[3] -> all 0; busy_o=0, pwm_we_o=0.
- last=1, loop=0; PERIOD0=100, HIGH0=40, HOLD0=5; PERIOD1=200, HIGH1=50, HOLD1=3; start -> exact write sequence:
  - (04,0), (00,100), (0A,40)
  - 5-cycle hold
  - (01,200), (0B,50)
  - 3-cycle hold
  - (04,1) with done_o in the same cycle.
- loop=1, last=0, HOLD0=0 -> A0/B0 writes repeat every 4 cycles (LOAD, WR_A, WR_B, HOLD); busy_o stays 1.
- stop_i asserted in the 2nd HOLD cycle -> next cycle writes (04,1), done_o=1, then IDLE. start_i with stop_i in IDLE -> no writes.
- Rewrite PERIOD1=300 during entry 0's HOLD -> the A1 write carries 300. start_i while busy -> no effect.
- Assert rst during WR_B -> pwm_we_o=0 immediately and tables cleared. With PWM_SEQ_IRQ_EN: irq_o=1 after done and 0 after writing 1 to STATUS.
